// File: rtl/adder_entry_ctrl_if.sv
// Channel bundle for adder_entry_ctrl: STDIN byte stream in, adder operands out,
// adder sum/carry back, and the captured result beat towards the display path.
interface adder_entry_ctrl_if #(
    parameter int W = 5
);
    logic         ch_valid;
    logic [7:0]   ch_data;
    logic         ch_ready;
    logic [W-1:0] add_x;
    logic [W-1:0] add_y;
    logic [W-1:0] add_s;
    logic         add_c;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_x;
    logic [W-1:0] res_y;
    logic [W-1:0] res_s;
    logic         res_c;
    logic         err;

    modport master (
        input  ch_valid, ch_data, add_s, add_c, res_ready,
        output ch_ready, add_x, add_y, res_valid, res_x, res_y, res_s, res_c, err
    );

    modport slave (
        output ch_valid, ch_data, add_s, add_c, res_ready,
        input  ch_ready, add_x, add_y, res_valid, res_x, res_y, res_s, res_c, err
    );
endinterface

// File: rtl/adder_entry_ctrl.sv
// Parses "DD<Enter>DD<Enter>" from a byte stream, loads the ripple adder operands,
// lets the adder settle, then presents {X, Y, S, C} as a single result beat.
module adder_entry_ctrl #(
    parameter int         W       = 5,
    parameter logic [7:0] ENTER_A = 8'h0A,
    parameter logic [7:0] ENTER_B = 8'h0D
) (
    input  logic                clk_i,
    input  logic                rst_i,
    adder_entry_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        X_HI, X_LO, X_END, Y_HI, Y_LO, Y_END, SETTLE, PRESENT
    } state_t;

    localparam logic [31:0] MAX_OP = (32'd1 << W) - 32'd1;

    state_t       state_q, state_d;
    logic [3:0]   tens_q, tens_d;
    logic [W-1:0] op_q, op_d;
    logic [W-1:0] add_x_q, add_x_d;
    logic [W-1:0] add_y_q, add_y_d;
    logic [W-1:0] res_x_q, res_x_d;
    logic [W-1:0] res_y_q, res_y_d;
    logic [W-1:0] res_s_q, res_s_d;
    logic         res_c_q, res_c_d;
    logic         res_valid_q, res_valid_d;
    logic         settle_q, settle_d;
    logic         err_q, err_d;
    logic         ch_ready_q, ch_ready_d;

    logic         byte_ok;
    logic         is_digit;
    logic         is_enter;
    logic         in_range;
    logic [7:0]   digit_full;
    logic [3:0]   digit;
    logic [6:0]   value7;

    assign byte_ok    = bus.ch_valid & ch_ready_q;
    assign is_digit   = (bus.ch_data >= 8'h30) && (bus.ch_data <= 8'h39);
    assign is_enter   = (bus.ch_data == ENTER_A) || (bus.ch_data == ENTER_B);
    assign digit_full = bus.ch_data - 8'h30;
    assign digit      = digit_full[3:0];
    assign value7     = ({3'b000, tens_q} * 7'd10) + {3'b000, digit};
    assign in_range   = ({25'd0, value7} <= MAX_OP);

    // Next-state and datapath updates; every error path restarts at X_HI.
    always_comb begin
        state_d     = state_q;
        tens_d      = tens_q;
        op_d        = op_q;
        add_x_d     = add_x_q;
        add_y_d     = add_y_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        res_s_d     = res_s_q;
        res_c_d     = res_c_q;
        res_valid_d = res_valid_q;
        settle_d    = settle_q;
        err_d       = 1'b0;
        case (state_q)
            X_HI, Y_HI: begin
                if (byte_ok && is_digit) begin
                    tens_d  = digit;
                    state_d = (state_q == X_HI) ? X_LO : Y_LO;
                end else if (byte_ok) begin
                    err_d   = 1'b1;
                    state_d = X_HI;
                end else begin
                    state_d = state_q;
                end
            end
            X_LO, Y_LO: begin
                if (byte_ok && is_digit && in_range) begin
                    op_d    = W'(value7);
                    state_d = (state_q == X_LO) ? X_END : Y_END;
                end else if (byte_ok) begin
                    err_d   = 1'b1;
                    state_d = X_HI;
                end else begin
                    state_d = state_q;
                end
            end
            X_END, Y_END: begin
                if (byte_ok && is_enter && (state_q == X_END)) begin
                    add_x_d = op_q;
                    state_d = Y_HI;
                end else if (byte_ok && is_enter) begin
                    add_y_d  = op_q;
                    settle_d = 1'b0;
                    state_d  = SETTLE;
                end else if (byte_ok) begin
                    err_d   = 1'b1;
                    state_d = X_HI;
                end else begin
                    state_d = state_q;
                end
            end
            // The adder gets one full cycle with stable operands before capture.
            SETTLE: begin
                if (settle_q) begin
                    res_x_d     = add_x_q;
                    res_y_d     = add_y_q;
                    res_s_d     = bus.add_s;
                    res_c_d     = bus.add_c;
                    res_valid_d = 1'b1;
                    state_d     = PRESENT;
                end else begin
                    settle_d = 1'b1;
                end
            end
            PRESENT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = X_HI;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = X_HI;
            end
        endcase
        ch_ready_d = (state_d != SETTLE) && (state_d != PRESENT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= X_HI;
            tens_q      <= 4'd0;
            op_q        <= '0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            res_s_q     <= '0;
            res_c_q     <= 1'b0;
            res_valid_q <= 1'b0;
            settle_q    <= 1'b0;
            err_q       <= 1'b0;
            ch_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            tens_q      <= tens_d;
            op_q        <= op_d;
            add_x_q     <= add_x_d;
            add_y_q     <= add_y_d;
            res_x_q     <= res_x_d;
            res_y_q     <= res_y_d;
            res_s_q     <= res_s_d;
            res_c_q     <= res_c_d;
            res_valid_q <= res_valid_d;
            settle_q    <= settle_d;
            err_q       <= err_d;
            ch_ready_q  <= ch_ready_d;
        end
    end

    assign bus.ch_ready  = ch_ready_q;
    assign bus.add_x     = add_x_q;
    assign bus.add_y     = add_y_q;
    assign bus.res_x     = res_x_q;
    assign bus.res_y     = res_y_q;
    assign bus.res_s     = res_s_q;
    assign bus.res_c     = res_c_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_adder_entry_ctrl.sv
// Directed plus randomized bench for adder_entry_ctrl; the expected behaviour comes
// from re-parsing the accepted byte history against the "DD<Enter>DD<Enter>" format.
module tb_adder_entry_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   exp_add_x = 0;
    int   exp_add_y = 0;
    logic [7:0] pend[$];

    adder_entry_ctrl_if #(.W(5)) bus();

    adder_entry_ctrl #(.W(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Behavioural 5-bit adder standing in for BigAdder.
    assign {bus.add_c, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y};

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic bit is_dig(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic bit is_ent(input logic [7:0] b);
        return (b == 8'h0A) || (b == 8'h0D);
    endfunction

    function automatic int operand(input int pos);
        return (int'(pend[pos]) - 48) * 10 + (int'(pend[pos + 1]) - 48);
    endfunction

    // Is the accepted history a valid prefix of a complete entry?
    function automatic bit pend_valid();
        for (int i = 0; i < pend.size(); i++) begin
            if ((i == 2) || (i == 5)) begin
                if (!is_ent(pend[i])) return 1'b0;
            end else begin
                if (!is_dig(pend[i])) return 1'b0;
            end
        end
        if ((pend.size() >= 2) && (operand(0) > 31)) return 1'b0;
        if ((pend.size() >= 5) && (operand(3) > 31)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_result(input int x, input int y, input int hold);
        int s;
        int c;
        s = (x + y) % 32;
        c = ((x + y) > 31) ? 1 : 0;
        chk("settle_ready", bus.ch_ready, 32'd0);
        chk("settle_valid_t0", bus.res_valid, 32'd0);
        tick();
        chk("settle_valid_t1", bus.res_valid, 32'd0);
        tick();
        chk("res_valid", bus.res_valid, 32'd1);
        chk("res_x", bus.res_x, x);
        chk("res_y", bus.res_y, y);
        chk("res_s", bus.res_s, s);
        chk("res_c", bus.res_c, c);
        for (int i = 0; i < hold; i++) begin
            bus.res_ready = 1'b0;
            bus.ch_valid  = 1'b1;
            bus.ch_data   = 8'($urandom_range(0, 255));
            tick();
            chk("hold_valid", bus.res_valid, 32'd1);
            chk("hold_s", bus.res_s, s);
            chk("hold_x", bus.res_x, x);
            chk("hold_ready", bus.ch_ready, 32'd0);
            chk("hold_err", bus.err, 32'd0);
        end
        bus.ch_valid  = 1'b1;
        bus.ch_data   = 8'h39;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        bus.ch_valid  = 1'b0;
        chk("hs_valid", bus.res_valid, 32'd0);
        chk("hs_ready", bus.ch_ready, 32'd1);
        chk("hs_err", bus.err, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        bus.ch_valid = 1'b1;
        bus.ch_data  = b;
        chk("ready_before_byte", bus.ch_ready, 32'd1);
        tick();
        bus.ch_valid = 1'b0;
        pend.push_back(b);
        if (!pend_valid()) begin
            chk("err_pulse", bus.err, 32'd1);
            pend.delete();
        end else begin
            chk("err_quiet", bus.err, 32'd0);
            if (pend.size() == 3) begin
                exp_add_x = operand(0);
                chk("add_x", bus.add_x, exp_add_x);
            end else if (pend.size() == 6) begin
                exp_add_y = operand(3);
                chk("add_y", bus.add_y, exp_add_y);
                check_result(exp_add_x, exp_add_y, hold);
                pend.delete();
            end else begin
                chk("add_x_kept", bus.add_x, exp_add_x);
            end
        end
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) send(s[i], hold);
    endtask

    task automatic send_num(input int v, input int hold);
        send(8'(48 + v / 10), hold);
        send(8'(48 + v % 10), hold);
        send(($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D, hold);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_err", bus.err, 32'd0);
            chk("idle_ready", bus.ch_ready, 32'd1);
        end
    endtask

    task automatic do_reset();
        bus.ch_valid = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_add_x", bus.add_x, 32'd0);
        chk("rst_add_y", bus.add_y, 32'd0);
        chk("rst_res_x", bus.res_x, 32'd0);
        chk("rst_res_y", bus.res_y, 32'd0);
        chk("rst_res_s", bus.res_s, 32'd0);
        chk("rst_res_c", bus.res_c, 32'd0);
        chk("rst_res_valid", bus.res_valid, 32'd0);
        chk("rst_err", bus.err, 32'd0);
        chk("rst_ch_ready", bus.ch_ready, 32'd1);
        pend.delete();
        exp_add_x = 0;
        exp_add_y = 0;
    endtask

    initial begin
        int r;
        logic [7:0] b;
        bus.ch_valid  = 1'b0;
        bus.ch_data   = 8'h00;
        bus.res_ready = 1'b0;
        tick();
        do_reset();

        send_str("17\n09\n", 0);
        send_str("31", 0);
        send(8'h0D, 0);
        send_str("31", 0);
        send(8'h0D, 0);
        send_str("3a", 0);
        send_str("05\n04\n", 0);
        send_str("45", 0);
        send_str("12\n", 0);
        send_str("7x", 0);
        send_str("00\n00\n", 10);
        send_str("32", 0);
        send_str("99", 0);
        send_str("1a", 0);
        send_str("20\n1", 0);
        do_reset();
        send_str("01\n01\n", 0);
        idle(2);

        for (int i = 0; i < 30; i++) begin
            send_num($urandom_range(0, 31), $urandom_range(0, 3));
            send_num($urandom_range(0, 31), $urandom_range(0, 3));
        end

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 6) begin
                idle(1);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 35)      b = 8'(8'h30 + $urandom_range(0, 3));
                else if (r < 65) b = 8'(8'h30 + $urandom_range(0, 9));
                else if (r < 82) b = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
                else             b = 8'($urandom_range(0, 255));
                send(b, $urandom_range(0, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
